// File: rtl/regfile_wb_sink_pkg.sv
// Shared constants for the write-back register file sink.
// Index widths, the x0 index and the zero word.
package regfile_wb_sink_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] X0     = '0;
  localparam logic [XLEN-1:0]      ZERO_W = '0;

  function automatic logic is_commit(
    input logic                 we,
    input logic [REG_IDX_W-1:0] rd
  );
    return we && (rd != X0);
  endfunction

endpackage

// File: rtl/regfile_wb_sink_if.sv
// Write-back bus from the WB stage into the register file.
// The WB stage is master; the register file is slave.
interface regfile_wb_sink_if #(
  parameter int XLEN = regfile_wb_sink_pkg::XLEN
);

  logic                                   WB_RegWrite;
  logic [XLEN-1:0]                        WB_WriteData;
  logic [regfile_wb_sink_pkg::REG_IDX_W-1:0] WB_Rd;
  logic [XLEN-1:0]                        WB_PC;

  modport master (
    output WB_RegWrite,
    output WB_WriteData,
    output WB_Rd,
    output WB_PC
  );

  modport slave (
    input WB_RegWrite,
    input WB_WriteData,
    input WB_Rd,
    input WB_PC
  );

endinterface

// File: rtl/regfile_wb_sink_read_port.sv
// One combinational read port: x0 and reset force zero,
// optional same-cycle forwarding of the committing write.
module regfile_read_port
  import regfile_wb_sink_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] i_idx,
  input  logic [XLEN-1:0]      i_word,
  input  logic                 i_commit,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]      i_wb_data,
  output logic [XLEN-1:0]      o_data
);

  logic w_hit;

  assign w_hit = BYPASS_EN && i_commit && (i_idx == i_wb_rd);

  always_comb begin
    o_data = XLEN'(ZERO_W);
    if (!reset_n || (i_idx == X0)) begin
      o_data = XLEN'(ZERO_W);
    end else if (w_hit) begin
      o_data = i_wb_data;
    end else begin
      o_data = i_word;
    end
  end

endmodule

// File: rtl/regfile_wb_sink.sv
// Integer register file terminating the WB stage, with
// two bypassed read ports, a debug port and commit bookkeeping.
module regfile_wb_sink
  import regfile_wb_sink_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_wb_sink_if.slave     wb,
  input  logic [REG_IDX_W-1:0] ID_Rs1,
  input  logic [REG_IDX_W-1:0] ID_Rs2,
  output logic [XLEN-1:0]      RF_Rs1Data,
  output logic [XLEN-1:0]      RF_Rs2Data,
  input  logic [REG_IDX_W-1:0] DBG_Addr,
  output logic [XLEN-1:0]      DBG_Data,
  output logic [CNT_W-1:0]     RF_WriteCount,
  output logic [XLEN-1:0]      RF_LastPC,
  output logic [REG_IDX_W-1:0] RF_LastRd
);

  logic [XLEN-1:0]      r_regs [NREGS];
  logic [CNT_W-1:0]     r_cnt;
  logic [XLEN-1:0]      r_last_pc;
  logic [REG_IDX_W-1:0] r_last_rd;
  logic                 w_commit;

  // A write arriving while reset is low is dropped.
  assign w_commit = reset_n && is_commit(wb.WB_RegWrite, wb.WB_Rd);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_cnt     <= '0;
      r_last_pc <= '0;
      r_last_rd <= '0;
    end else if (w_commit) begin
      r_regs[wb.WB_Rd] <= wb.WB_WriteData;
      r_cnt     <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      r_last_pc <= wb.WB_PC;
      r_last_rd <= wb.WB_Rd;
    end
  end

  regfile_read_port #(.XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) u_rd1 (
    .reset_n   (reset_n),
    .i_idx     (ID_Rs1),
    .i_word    (r_regs[ID_Rs1]),
    .i_commit  (w_commit),
    .i_wb_rd   (wb.WB_Rd),
    .i_wb_data (wb.WB_WriteData),
    .o_data    (RF_Rs1Data)
  );

  regfile_read_port #(.XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) u_rd2 (
    .reset_n   (reset_n),
    .i_idx     (ID_Rs2),
    .i_word    (r_regs[ID_Rs2]),
    .i_commit  (w_commit),
    .i_wb_rd   (wb.WB_Rd),
    .i_wb_data (wb.WB_WriteData),
    .o_data    (RF_Rs2Data)
  );

  regfile_read_port #(.XLEN(XLEN), .BYPASS_EN(1'b0)) u_dbg (
    .reset_n   (reset_n),
    .i_idx     (DBG_Addr),
    .i_word    (r_regs[DBG_Addr]),
    .i_commit  (1'b0),
    .i_wb_rd   (X0),
    .i_wb_data (XLEN'(ZERO_W)),
    .o_data    (DBG_Data)
  );

  assign RF_WriteCount = r_cnt;
  assign RF_LastPC     = r_last_pc;
  assign RF_LastRd     = r_last_rd;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench: a bypassing 64-bit-counter instance and a
// non-bypassing 2-bit-counter instance share one WB bus.
module tb_regfile_wb_sink;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rs1, rs2, dbg;

  logic [31:0] b_rs1, b_rs2, b_dbg, b_lpc;
  logic [63:0] b_cnt;
  logic [4:0]  b_lrd;
  logic [31:0] n_rs1, n_rs2, n_dbg, n_lpc;
  logic [1:0]  n_cnt;
  logic [4:0]  n_lrd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_sink_if wb ();

  regfile_wb_sink #(.BYPASS_EN(1'b1), .CNT_W(64)) dut_b (
    .clk (clk), .reset_n (reset_n), .wb (wb),
    .ID_Rs1 (rs1), .ID_Rs2 (rs2),
    .RF_Rs1Data (b_rs1), .RF_Rs2Data (b_rs2),
    .DBG_Addr (dbg), .DBG_Data (b_dbg),
    .RF_WriteCount (b_cnt), .RF_LastPC (b_lpc),
    .RF_LastRd (b_lrd)
  );

  regfile_wb_sink #(.BYPASS_EN(1'b0), .CNT_W(2)) dut_n (
    .clk (clk), .reset_n (reset_n), .wb (wb),
    .ID_Rs1 (rs1), .ID_Rs2 (rs2),
    .RF_Rs1Data (n_rs1), .RF_Rs2Data (n_rs2),
    .DBG_Addr (dbg), .DBG_Data (n_dbg),
    .RF_WriteCount (n_cnt), .RF_LastPC (n_lpc),
    .RF_LastRd (n_lrd)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd,
                       input logic [31:0] d, input logic [31:0] pc);
    wb.WB_RegWrite  = we;
    wb.WB_Rd        = rd;
    wb.WB_WriteData = d;
    wb.WB_PC        = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg;
    logic [31:0] b1;
    logic [31:0] n1;
    logic [31:0] b2;
    logic [31:0] n2;
    logic [31:0] dg;
    logic [63:0] cnt;
    logic [31:0] lpc;
    logic [4:0]  lrd;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{1'b1, 5'd3, 32'h12345678, 32'h100, 5'd3, 5'd0, 5'd3,
              32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0,
              64'd1, 32'h100, 5'd3};
    vt[1] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3,
              32'h12345678, 32'h12345678, 32'h12345678,
              32'h12345678, 32'h12345678,
              64'd1, 32'h100, 5'd3};
    vt[2] = '{1'b1, 5'd7, 32'hA5A5A5A5, 32'h104, 5'd7, 5'd7, 5'd7,
              32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0,
              64'd2, 32'h104, 5'd7};
    vt[3] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd3, 5'd7,
              32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678,
              32'h12345678, 32'hA5A5A5A5,
              64'd2, 32'h104, 5'd7};
    vt[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 32'h200, 5'd0, 5'd7, 5'd0,
              32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,
              64'd2, 32'h104, 5'd7};
    vt[5] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              64'd2, 32'h104, 5'd7};
    for (int k = 6; k < 9; k++) begin
      vt[k] = '{1'b0, 5'd9, 32'h55, 32'h300, 5'd9, 5'd9, 5'd9,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                64'd2, 32'h104, 5'd7};
    end
    vt[9] = '{1'b1, 5'd7, 32'h0BADF00D, 32'h108, 5'd7, 5'd3, 5'd7,
              32'h0BADF00D, 32'hA5A5A5A5, 32'h12345678,
              32'h12345678, 32'hA5A5A5A5,
              64'd3, 32'h108, 5'd7};

    // Reset held two cycles with a write on the bus.
    reset_n = 1'b0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 32'h40);
    rs1 = 5'd5; rs2 = 5'd5; dbg = 5'd5;
    #1;
    chk("rst_rs1_forced", {32'h0, b_rs1}, 64'h0);
    chk("rst_rs2_forced", {32'h0, b_rs2}, 64'h0);
    tick();
    tick();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("rst_reg5_rs1", {32'h0, b_rs1}, 64'h0);
    chk("rst_reg5_dbg", {32'h0, b_dbg}, 64'h0);
    chk("rst_cnt", b_cnt, 64'h0);
    chk("rst_cnt_n", {62'h0, n_cnt}, 64'h0);
    chk("rst_lpc", {32'h0, b_lpc}, 64'h0);
    chk("rst_lrd", {59'h0, b_lrd}, 64'h0);

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].we, vt[i].rd, vt[i].data, vt[i].pc);
      rs1 = vt[i].rs1; rs2 = vt[i].rs2; dbg = vt[i].dbg;
      #1;
      chk($sformatf("v%0d_b_rs1", i), {32'h0, b_rs1}, {32'h0, vt[i].b1});
      chk($sformatf("v%0d_n_rs1", i), {32'h0, n_rs1}, {32'h0, vt[i].n1});
      chk($sformatf("v%0d_b_rs2", i), {32'h0, b_rs2}, {32'h0, vt[i].b2});
      chk($sformatf("v%0d_n_rs2", i), {32'h0, n_rs2}, {32'h0, vt[i].n2});
      chk($sformatf("v%0d_b_dbg", i), {32'h0, b_dbg}, {32'h0, vt[i].dg});
      chk($sformatf("v%0d_n_dbg", i), {32'h0, n_dbg}, {32'h0, vt[i].dg});
      tick();
      chk($sformatf("v%0d_cnt", i), b_cnt, vt[i].cnt);
      chk($sformatf("v%0d_cnt_n", i), {62'h0, n_cnt},
          {62'h0, vt[i].cnt[1:0]});
      chk($sformatf("v%0d_lpc", i), {32'h0, b_lpc}, {32'h0, vt[i].lpc});
      chk($sformatf("v%0d_lrd", i), {59'h0, b_lrd}, {59'h0, vt[i].lrd});
    end

    // Back-to-back commits; the 2-bit counter wraps from 3.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h11111111 * i, 32'h400 + 32'(4 * i));
      tick();
      chk($sformatf("b2b%0d_cnt", i), b_cnt, 64'(3 + i));
      chk($sformatf("b2b%0d_cnt_n", i), {62'h0, n_cnt},
          64'((3 + i) % 4));
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      rs1 = 5'(i); dbg = 5'(i);
      #1;
      chk($sformatf("b2b_reg%0d_dbg", i), {32'h0, b_dbg},
          {32'h0, 32'h11111111 * i});
      chk($sformatf("b2b_reg%0d_n_rs1", i), {32'h0, n_rs1},
          {32'h0, 32'h11111111 * i});
    end
    chk("b2b_lrd", {59'h0, b_lrd}, 64'd4);
    chk("b2b_lpc", {32'h0, n_lpc}, 64'h410);

    // Reset mid-stream, then commit on the first released edge.
    reset_n = 1'b0;
    drive(1'b1, 5'd6, 32'hCAFEF00D, 32'h500);
    rs1 = 5'd6; rs2 = 5'd1; dbg = 5'd1;
    #1;
    chk("mrst_rs1", {32'h0, b_rs1}, 64'h0);
    chk("mrst_rs2", {32'h0, b_rs2}, 64'h0);
    chk("mrst_dbg", {32'h0, b_dbg}, 64'h0);
    tick();
    reset_n = 1'b1;
    drive(1'b1, 5'd2, 32'h22220000, 32'h600);
    rs1 = 5'd1; rs2 = 5'd2; dbg = 5'd6;
    #1;
    chk("mrst_cnt", b_cnt, 64'h0);
    chk("mrst_cnt_n", {62'h0, n_cnt}, 64'h0);
    chk("mrst_lpc", {32'h0, b_lpc}, 64'h0);
    chk("mrst_reg1", {32'h0, b_rs1}, 64'h0);
    chk("mrst_b_byp", {32'h0, b_rs2}, 64'h22220000);
    chk("mrst_n_byp", {32'h0, n_rs2}, 64'h0);
    chk("mrst_reg6", {32'h0, b_dbg}, 64'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    rs1 = 5'd2;
    #1;
    chk("first_cnt", b_cnt, 64'd1);
    chk("first_reg2", {32'h0, b_rs1}, 64'h22220000);
    chk("first_lrd", {59'h0, b_lrd}, 64'd2);
    chk("first_lpc", {32'h0, b_lpc}, 64'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
